zap_predecode_branch_predictor: RTL
===================================

# zap_predecode_branch_predictor

Parametrised dynamic branch predictor for the ZAP predecode stage. It replaces the pass-through of an externally supplied 2-bit branch state with an internal table of 2-bit saturating counters, indexed by PC and optionally hashed with global history. The table is updated from the execute-side resolution port. It sits between the Thumb decompressor output and the memory/BL/multiply FSM chain, and issues the decode-stage redirect to fetch.

## Interface
Parameters:
- INDEX_BITS, 6: log2 of counter-table entries (range 2..8).
- HIST_BITS, 6: global history length; must be ≤ INDEX_BITS. Used only when ZAP_BP_GSHARE_EN is defined.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter, i_stall_from_issue  in  1 each  pipeline control, in that priority order.
- i_instruction  in  35  decompressed instruction; bit 34 = Thumb (offset shift 1).
- i_instruction_valid  in  1  instruction qualifier.
- i_pc_ff, i_pc_plus_8_ff  in  32  PC of the instruction and PC+8.
- i_upd_valid  in  1  branch resolved this cycle.
- i_upd_index  in  INDEX_BITS  table index carried with the branch.
- i_upd_taken  in  1  actual branch outcome.
- o_instruction_ff  out  35  registered instruction.
- o_instruction_valid_ff  out  1  registered valid.
- o_pc_ff, o_pc_plus_8_ff  out  32  registered PCs.
- o_taken_ff  out  2  registered predicted state: SNT=0, WNT=1, WT=2, ST=3.
- o_bp_index_ff  out  INDEX_BITS  registered lookup index; travels with the instruction back to i_upd_index.
- o_clear_from_decode  out  1  combinational redirect request.
- o_pc_from_decode  out  32  combinational redirect target; 0 when there is no redirect.

## Operation
- Lookup index is computed as follows:
  - Without gshare: idx = i_pc_ff[INDEX_BITS:1].
  - With gshare: the GHR is zero-extended to INDEX_BITS and XORed into that value.
- Branch detection: is_br = i_instruction_valid && i_instruction[27:25]==3'b101.
- Counter read uses read-during-write bypass. If i_upd_valid and i_upd_index==idx in the same cycle, the lookup sees the post-update counter value.
- Prediction:
  - taken_nxt = (cond==AL) ? ST : ctr[idx].
  - Non-branches also carry ctr[idx] in taken_nxt, for debug only.
- Redirect:
  - o_clear_from_decode = is_br && (ctr[1] || cond==AL) && no clear or stall input active.
  - Target = i_pc_plus_8_ff + (sext(imm24) << (bit34 ? 1 : 2)), truncated to 32 bits (wrap-around).
- Pipeline register, with first matching row winning:
  - reset → clear all outputs.
  - writeback clear → clear.
  - data stall → hold.
  - alu clear → clear.
  - shifter stall → hold.
  - issue stall → hold.
  - otherwise → load.
- Cleared values: all outputs 0, except o_pc_plus_8_ff = 32'd8.
- Update:
  - On i_upd_valid, ctr[i_upd_index] saturating-increments if taken (ST stays ST) and saturating-decrements if not taken (SNT stays SNT).
  - Updates are applied regardless of stall and clear. They are suppressed only by i_reset.

## Timing
- Reset (1 cycle): every counter becomes WNT and GHR = 0.
- Registered outputs are valid 1 cycle after a non-stalled, non-cleared edge.
- o_clear_from_decode and o_pc_from_decode are combinational from the current-cycle inputs: zero-cycle redirect.
- Counter update is visible to a lookup in the same cycle (bypass) and to every later cycle.
- Simultaneous i_reset and i_upd_valid: reset wins, and the table holds the reset values.
- Reset mid-stall: reset wins, and outputs clear on that edge.

## Configuration
- ZAP_BP_GSHARE_EN defined:
  - A HIST_BITS GHR shifts left on every i_upd_valid, inserting i_upd_taken into the LSB.
  - The lookup index is XOR-hashed with the GHR as described above.
- Undefined: no GHR flops exist, and indexing is pure bimodal. All ports remain identical.

## Structure
- Shared package zap_bp_pkg holds:
  - localparams SNT/WNT/WT/ST and AL=4'b1110.
  - Function sat_update(state, taken).
- Sub-module zap_bp_counter_table: 2^INDEX_BITS × 2-bit flop array, synchronous reset to WNT, one write port, one bypassed read port.
- Top level: index hash, branch detect, target adder, pipeline register, GHR.

## Test plan
- Reset, then an unconditional branch (cond=AL, imm24=24'h000004, ARM, pc_plus_8=0x108) → o_clear_from_decode=1, o_pc_from_decode=0x118; next cycle o_taken_ff=3.
- Conditional branch at a fresh index (counter WNT) → no redirect, o_taken_ff=1. Two updates with taken=1 → the next lookup redirects and o_taken_ff=3. A third taken update leaves ST.
- Thumb branch (bit34=1, imm24=24'hFFFFFE, pc_plus_8=0x4) → target 0x0000_0000. imm24=all-ones with pc_plus_8=0 → 0xFFFF_FFFC (wrap).
- Update and lookup on the same index in the same cycle, with the counter at WNT and taken=1 → the lookup sees WT and redirects.
- Stall and clear priority:
  - i_data_stall with i_clear_from_alu → outputs hold.
  - i_clear_from_writeback with a stall → outputs cleared, o_pc_plus_8_ff=8.
  - In both cases o_clear_from_decode=0.
- With ZAP_BP_GSHARE_EN and HIST_BITS=2: updates taken,taken → GHR=2'b11. The same PC then indexes i_pc_ff[INDEX_BITS:1]^3, and o_bp_index_ff reflects it.

Source files
------------

// File: rtl/zap_bp_pkg.sv
// Shared constants and counter helper for the ZAP predecode branch predictor.
// Counter states, the "always" condition code and the saturating-update function.
package zap_bp_pkg;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [3:0] AL = 4'b1110;

  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    if (taken) begin
      return (state == ST) ? ST : state + 2'd1;
    end else begin
      return (state == SNT) ? SNT : state - 2'd1;
    end
  endfunction

endpackage

// File: rtl/zap_predecode_branch_predictor_if.sv
// Bus between the Thumb decompressor/execute side and the predecode branch predictor.
// master drives the i_* signals, slave (the predictor) drives the o_* signals.
interface zap_predecode_branch_predictor_if #(
  parameter int unsigned INDEX_BITS = 6
);
  logic                  i_clear_from_writeback;
  logic                  i_data_stall;
  logic                  i_clear_from_alu;
  logic                  i_stall_from_shifter;
  logic                  i_stall_from_issue;
  logic [34:0]           i_instruction;
  logic                  i_instruction_valid;
  logic [31:0]           i_pc_ff;
  logic [31:0]           i_pc_plus_8_ff;
  logic                  i_upd_valid;
  logic [INDEX_BITS-1:0] i_upd_index;
  logic                  i_upd_taken;
  logic [34:0]           o_instruction_ff;
  logic                  o_instruction_valid_ff;
  logic [31:0]           o_pc_ff;
  logic [31:0]           o_pc_plus_8_ff;
  logic [1:0]            o_taken_ff;
  logic [INDEX_BITS-1:0] o_bp_index_ff;
  logic                  o_clear_from_decode;
  logic [31:0]           o_pc_from_decode;

  modport master (
    output i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter,
    output i_stall_from_issue, i_instruction, i_instruction_valid, i_pc_ff, i_pc_plus_8_ff,
    output i_upd_valid, i_upd_index, i_upd_taken,
    input  o_instruction_ff, o_instruction_valid_ff, o_pc_ff, o_pc_plus_8_ff, o_taken_ff,
    input  o_bp_index_ff, o_clear_from_decode, o_pc_from_decode
  );

  modport slave (
    input  i_clear_from_writeback, i_data_stall, i_clear_from_alu, i_stall_from_shifter,
    input  i_stall_from_issue, i_instruction, i_instruction_valid, i_pc_ff, i_pc_plus_8_ff,
    input  i_upd_valid, i_upd_index, i_upd_taken,
    output o_instruction_ff, o_instruction_valid_ff, o_pc_ff, o_pc_plus_8_ff, o_taken_ff,
    output o_bp_index_ff, o_clear_from_decode, o_pc_from_decode
  );
endinterface

// File: rtl/zap_bp_counter_table.sv
// Table of 2-bit saturating counters: one write port, one read port that
// returns the post-update value when reading the entry being written.
module zap_bp_counter_table #(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [INDEX_BITS-1:0] i_wr_index,
  input  logic                  i_wr_taken,
  input  logic [INDEX_BITS-1:0] i_rd_index,
  output logic [1:0]            o_rd_state
);
  import zap_bp_pkg::*;

  localparam int unsigned Entries = 1 << INDEX_BITS;

  logic [1:0] r_ctr [Entries];
  logic [1:0] w_wr_next;

  assign w_wr_next = sat_update(r_ctr[i_wr_index], i_wr_taken);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < Entries; i++) begin
        r_ctr[i] <= WNT;
      end
    end else if (i_wr_en) begin
      r_ctr[i_wr_index] <= w_wr_next;
    end
  end

  assign o_rd_state = (i_wr_en && (i_wr_index == i_rd_index)) ? w_wr_next : r_ctr[i_rd_index];

endmodule

// File: rtl/zap_predecode_branch_predictor.sv
// Predecode-stage dynamic branch predictor with zero-cycle redirect to fetch.
// Define ZAP_BP_GSHARE_EN to hash the lookup index with a global history register.
module zap_predecode_branch_predictor #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned HIST_BITS  = 6
) (
  input logic                              i_clk,
  input logic                              i_reset,
  zap_predecode_branch_predictor_if.slave  bus
);
  import zap_bp_pkg::*;

  if (INDEX_BITS < 2 || INDEX_BITS > 8 || HIST_BITS < 1 || HIST_BITS > INDEX_BITS) begin : g_bad_cfg
    $error("zap_predecode_branch_predictor: unsupported INDEX_BITS/HIST_BITS");
  end

  logic [INDEX_BITS-1:0] w_pc_index;
  logic [INDEX_BITS-1:0] w_lookup_index;
  logic [1:0]            w_ctr;
  logic [3:0]            w_cond;
  logic                  w_is_br;
  logic                  w_blocked;
  logic                  w_redirect;
  logic [1:0]            w_taken_nxt;
  logic [31:0]           w_imm_sext;
  logic [31:0]           w_offset;
  logic [31:0]           w_target;

  assign w_pc_index = bus.i_pc_ff[INDEX_BITS:1];

`ifdef ZAP_BP_GSHARE_EN
  logic [HIST_BITS-1:0]  r_ghr;
  logic [HIST_BITS:0]    w_ghr_shift;
  logic [INDEX_BITS-1:0] w_ghr_ext;

  assign w_ghr_shift = {r_ghr, bus.i_upd_taken};

  always_comb begin
    w_ghr_ext                = '0;
    w_ghr_ext[HIST_BITS-1:0] = r_ghr;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ghr <= '0;
    end else if (bus.i_upd_valid) begin
      r_ghr <= w_ghr_shift[HIST_BITS-1:0];
    end
  end

  assign w_lookup_index = w_pc_index ^ w_ghr_ext;
`else
  assign w_lookup_index = w_pc_index;
`endif

  zap_bp_counter_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr_en    (bus.i_upd_valid),
    .i_wr_index (bus.i_upd_index),
    .i_wr_taken (bus.i_upd_taken),
    .i_rd_index (w_lookup_index),
    .o_rd_state (w_ctr)
  );

  assign w_cond      = bus.i_instruction[31:28];
  assign w_is_br     = bus.i_instruction_valid && (bus.i_instruction[27:25] == 3'b101);
  assign w_taken_nxt = (w_cond == AL) ? ST : w_ctr;
  assign w_blocked   = bus.i_clear_from_writeback | bus.i_data_stall | bus.i_clear_from_alu |
                       bus.i_stall_from_shifter | bus.i_stall_from_issue;
  assign w_redirect  = w_is_br && (w_ctr[1] || (w_cond == AL)) && !w_blocked;

  // Thumb branch offsets are halfword-scaled, ARM offsets word-scaled.
  assign w_imm_sext = {{8{bus.i_instruction[23]}}, bus.i_instruction[23:0]};
  assign w_offset   = bus.i_instruction[34] ? (w_imm_sext << 1) : (w_imm_sext << 2);
  assign w_target   = bus.i_pc_plus_8_ff + w_offset;

  assign bus.o_clear_from_decode = w_redirect;
  assign bus.o_pc_from_decode    = w_redirect ? w_target : 32'd0;

  logic [34:0]           r_instruction;
  logic                  r_instruction_valid;
  logic [31:0]           r_pc;
  logic [31:0]           r_pc_plus_8;
  logic [1:0]            r_taken;
  logic [INDEX_BITS-1:0] r_bp_index;

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_clear_from_writeback ||
        (!bus.i_data_stall && bus.i_clear_from_alu)) begin
      r_instruction       <= '0;
      r_instruction_valid <= 1'b0;
      r_pc                <= 32'd0;
      r_pc_plus_8         <= 32'd8;
      r_taken             <= SNT;
      r_bp_index          <= '0;
    end else if (!bus.i_data_stall && !bus.i_stall_from_shifter && !bus.i_stall_from_issue) begin
      r_instruction       <= bus.i_instruction;
      r_instruction_valid <= bus.i_instruction_valid;
      r_pc                <= bus.i_pc_ff;
      r_pc_plus_8         <= bus.i_pc_plus_8_ff;
      r_taken             <= w_taken_nxt;
      r_bp_index          <= w_lookup_index;
    end
  end

  assign bus.o_instruction_ff       = r_instruction;
  assign bus.o_instruction_valid_ff = r_instruction_valid;
  assign bus.o_pc_ff                = r_pc;
  assign bus.o_pc_plus_8_ff         = r_pc_plus_8;
  assign bus.o_taken_ff             = r_taken;
  assign bus.o_bp_index_ff          = r_bp_index;

endmodule
